fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter and fetch controller for the 9-bit-instruction instruction ROM. On start it walks the
//  ROM from RESET_PC and presents one registered instruction per cycle to decode, with the address it
//  came from. It also applies absolute/relative branches (squashing the wrong-path fetch), honours
//  datapath stalls, and stops on the HALT encoding. Sits between top-level start/done and the core datapath.
// PARAMETERS
//  D          12           ROM address width; PC wraps modulo 2**D
//  W          9            instruction width (must equal ROM word width)
//  RESET_PC   '0           first fetch address after start
//  HALT_CODE  9'h1FF       encoding that ends the program
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  start          in   1   pulse; begins a run from IDLE or DONE
//  stall          in   1   datapath hold request
//  branch_taken   in   1   decode/execute resolves taken branch for current instr
//  branch_rel     in   1   1: target = instr_pc + branch_target (signed); 0: absolute
//  branch_target  in   D   absolute address or two's-complement offset
//  rom_addr       out  D   combinational ROM address (= pc)
//  rom_data       in   W   combinational ROM read data for rom_addr
//  instr          out  W   registered instruction to decode
//  instr_valid    out  1   instr is valid for execution this cycle
//  instr_pc       out  D   address instr was fetched from
//  busy           out  1   high in RUN
//  done           out  1   high in DONE until next start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, instr_pc=0, busy=0, done=0.
//  States: IDLE, RUN, DONE. rom_addr=pc at all times.
//  IDLE/DONE: start -> RUN next edge; pc=RESET_PC, instr_valid=0, done cleared on that edge.
//  RUN, stall=0 (advance): instr<=rom_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (mod 2**D).
//   First valid instr appears 1 cycle after entering RUN (fetch latency 1).
//  RUN, stall=1: pc, instr, instr_valid, instr_pc all hold; branch_taken ignored; no halt detection.
//  Branch: sampled only when instr_valid=1 and stall=0. Next edge: pc<=target, instr_valid<=0
//   (wrong-path word at pc is squashed); the following edge fetches target. Taken-branch penalty = 1 bubble.
//   target = branch_rel ? (instr_pc + branch_target) mod 2**D : branch_target.
//  Halt: instr_valid=1, instr==HALT_CODE, stall=0 -> next edge state=DONE, done=1, busy=0,
//   instr_valid=0; pc holds. HALT has priority over a simultaneous branch_taken.
//  start while RUN is ignored. branch_taken with instr_valid=0 is ignored.
//  Wrap-around: pc at 2**D-1 advances to 0 without error; relative targets wrap the same way.
//  rst_n asserted mid-run: immediate return to reset values; no further fetch until start.
//  busy = (state==RUN); done = (state==DONE); both registered state decodes, no glitching.
// STRUCTURE
//  Package fetch_pkg: state enum fetch_state_t {IDLE,RUN,DONE}, HALT_CODE constant, default D/W
//   localparams shared with instruction ROM and decoder.
//  Sub-module next_pc_calc: combinational pc+1 / absolute / relative target mux with wrap; rest is one
//   always_ff state/PC/IR process plus an always_comb next-state block.
// TESTING
//  1 Reset then start with ROM[0..3]={0x0F0,0x0CC,0x0F4,0x1FF}: instr_valid from cycle 2, instr_pc 0,1,2,3
//    in consecutive cycles; done=1 the cycle after HALT is presented; busy=0.
//  2 Absolute branch: branch_taken=1, branch_rel=0, target=0x100 while instr_pc=2 -> one bubble
//    (instr_valid=0), then instr_pc=0x100 with instr=ROM[0x100].
//  3 Relative backward branch: instr_pc=5, branch_target=12'hFFD (-3) -> next valid instr_pc=2;
//    instr_pc=1, offset -3 -> wraps to 0xFFE.
//  4 Stall for 3 cycles mid-run, including with branch_taken=1 held -> all outputs frozen, branch not
//    taken; after release, sequence resumes with no lost or duplicated instruction.
//  5 PC wrap: branch to 0xFFF with ROM[0xFFF]=0x001, ROM[0]=0x1FF -> instr_pc 0xFFF then 0x000, then done.
//  6 rst_n low for 1 cycle mid-run -> all outputs at reset values asynchronously; start -> restart
//    from RESET_PC; start during RUN has no effect.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-side definitions: sequencer states, HALT encoding and default ROM geometry.
// The instruction ROM and decoder import the same defaults so the widths stay in step.
package fetch_pkg;

    localparam int FETCH_D = 12;
    localparam int FETCH_W = 9;
    localparam logic [FETCH_W-1:0] HALT_CODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the control handshake, the ROM port and the decode-side outputs of the fetch sequencer.
// The sequencer connects through the master modport; its environment uses the slave modport.
interface fetch_sequencer_if #(
    parameter int D = fetch_pkg::FETCH_D,
    parameter int W = fetch_pkg::FETCH_W
);
    logic         start;
    logic         stall;
    logic         branch_taken;
    logic         branch_rel;
    logic [D-1:0] branch_target;
    logic [D-1:0] rom_addr;
    logic [W-1:0] rom_data;
    logic [W-1:0] instr;
    logic         instr_valid;
    logic [D-1:0] instr_pc;
    logic         busy;
    logic         done;

    modport master (
        input  start, stall, branch_taken, branch_rel, branch_target, rom_data,
        output rom_addr, instr, instr_valid, instr_pc, busy, done
    );

    modport slave (
        output start, stall, branch_taken, branch_rel, branch_target, rom_data,
        input  rom_addr, instr, instr_valid, instr_pc, busy, done
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Next-PC selection: sequential increment or taken-branch target (absolute or instr_pc-relative).
// All arithmetic is D bits wide, so the PC and relative targets wrap modulo 2**D for free.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int D = FETCH_D
) (
    input  logic [D-1:0] pc_i,
    input  logic [D-1:0] instr_pc_i,
    input  logic [D-1:0] branch_target_i,
    input  logic         take_branch_i,
    input  logic         branch_rel_i,
    output logic [D-1:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i + {{(D-1){1'b0}}, 1'b1};
        if (take_branch_i) begin
            // A negative offset is simply the two's-complement D-bit value; truncation gives the wrap.
            next_pc_o = branch_rel_i ? (instr_pc_i + branch_target_i) : branch_target_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: walks the instruction ROM, presents one registered
// instruction per cycle, applies branches with a one-bubble squash, honours stalls, stops on HALT.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int           D         = FETCH_D,
    parameter int           W         = FETCH_W,
    parameter logic [D-1:0] RESET_PC  = '0,
    parameter logic [W-1:0] HALT_CODE = fetch_pkg::HALT_CODE
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   bus
);

    fetch_state_t state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [W-1:0] instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [D-1:0] instr_pc_q, instr_pc_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         is_halt;
    logic         take_branch;
    logic [D-1:0] next_pc;

    assign is_halt     = instr_valid_q && (instr_q == HALT_CODE);
    assign take_branch = (state_q == RUN) && !bus.stall && instr_valid_q
                         && bus.branch_taken && !is_halt;

    next_pc_calc #(.D(D)) u_next_pc (
        .pc_i            (pc_q),
        .instr_pc_i      (instr_pc_q),
        .branch_target_i (bus.branch_target),
        .take_branch_i   (take_branch),
        .branch_rel_i    (bus.branch_rel),
        .next_pc_o       (next_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        instr_pc_d    = instr_pc_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d       = RUN;
                    pc_d          = RESET_PC;
                    instr_valid_d = 1'b0;
                end
            end
            RUN: begin
                // HALT beats a taken branch; a branch squashes the word currently addressed by pc.
                if (!bus.stall) begin
                    if (is_halt) begin
                        state_d       = DONE;
                        instr_valid_d = 1'b0;
                    end else if (take_branch) begin
                        pc_d          = next_pc;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = bus.rom_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = next_pc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            instr_pc_q    <= instr_pc_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; the ROM is a bench array read combinationally at rom_addr.
// Unless a test overrides it, ROM[a] = {1'b0, a[7:0]} so HALT never appears by accident.
module tb_fetch_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [8:0] rom [0:4095];

    fetch_sequencer_if #(.D(12), .W(9)) bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fillRom();
        for (int i = 0; i < 4096; i++) begin
            logic [11:0] a;
            a = i[11:0];
            rom[i] = {1'b0, a[7:0]};
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic startRun();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr}
            !== {1'b0, 1'b0, 1'b0, 12'h000, 9'h000, 12'h000}) begin
            failures++;
            $display("[TB] FAIL reset_values actual=%h required=%h",
                {bus.busy, bus.done, bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr},
                {1'b0, 1'b0, 1'b0, 12'h000, 9'h000, 12'h000});
        end
    endtask

    task automatic test_sequential_run();
        logic [8:0] expInstr [4];
        expInstr = '{9'h0F0, 9'h0CC, 9'h0F4, 9'h1FF};
        for (int i = 0; i < 4; i++) rom[i] = expInstr[i];
        rst_n = 1'b1;
        step();
        startRun();
        checks++;
        if ({bus.busy, bus.done, bus.instr_valid} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL run_entry actual=%b required=%b",
                {bus.busy, bus.done, bus.instr_valid}, 3'b100);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'(i), expInstr[i]}) begin
                failures++;
                $display("[TB] FAIL seq_fetch_%0d actual=%h required=%h", i,
                    {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'(i), expInstr[i]});
            end
        end
        step();
        checks++;
        if ({bus.busy, bus.done, bus.instr_valid} !== 3'b010) begin
            failures++;
            $display("[TB] FAIL halt_done actual=%b required=%b",
                {bus.busy, bus.done, bus.instr_valid}, 3'b010);
        end
    endtask

    task automatic test_absolute_branch();
        fillRom();
        rom[12'h100] = 9'h0AB;
        startRun();
        checks++;
        if ({bus.busy, bus.done, bus.instr_valid} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL restart_from_done actual=%b required=%b",
                {bus.busy, bus.done, bus.instr_valid}, 3'b100);
        end
        repeat (3) step();
        bus.branch_taken  = 1'b1;
        bus.branch_rel    = 1'b0;
        bus.branch_target = 12'h100;
        step();
        bus.branch_taken = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.rom_addr} !== {1'b0, 12'h100}) begin
            failures++;
            $display("[TB] FAIL abs_bubble actual=%h required=%h",
                {bus.instr_valid, bus.rom_addr}, {1'b0, 12'h100});
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'h100, 9'h0AB}) begin
            failures++;
            $display("[TB] FAIL abs_target actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h100, 9'h0AB});
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'h101, 9'h001}) begin
            failures++;
            $display("[TB] FAIL abs_follow actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h101, 9'h001});
        end
    endtask

    task automatic test_relative_branch();
        doReset();
        startRun();
        repeat (6) step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 12'h005}) begin
            failures++;
            $display("[TB] FAIL rel_setup actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc}, {1'b1, 12'h005});
        end
        bus.branch_taken  = 1'b1;
        bus.branch_rel    = 1'b1;
        bus.branch_target = 12'hFFD;
        step();
        bus.branch_taken = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rel_bubble actual=%b required=%b", bus.instr_valid, 1'b0);
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'h002, 9'h002}) begin
            failures++;
            $display("[TB] FAIL rel_backward actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h002, 9'h002});
        end
        doReset();
        startRun();
        repeat (2) step();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 12'hFFD;
        step();
        bus.branch_taken = 1'b0;
        bus.branch_rel   = 1'b0;
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'hFFE, 9'h0FE}) begin
            failures++;
            $display("[TB] FAIL rel_wrap actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'hFFE, 9'h0FE});
        end
    endtask

    task automatic test_stall();
        doReset();
        startRun();
        repeat (3) step();
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_rel    = 1'b0;
        bus.branch_target = 12'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr, bus.busy}
                !== {1'b1, 12'h002, 9'h002, 12'h003, 1'b1}) begin
                failures++;
                $display("[TB] FAIL stall_hold_%0d actual=%h required=%h", i,
                    {bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr, bus.busy},
                    {1'b1, 12'h002, 9'h002, 12'h003, 1'b1});
            end
        end
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'h003, 9'h003}) begin
            failures++;
            $display("[TB] FAIL stall_resume actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h003, 9'h003});
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 12'h004}) begin
            failures++;
            $display("[TB] FAIL stall_resume_next actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc}, {1'b1, 12'h004});
        end
    endtask

    task automatic test_wrap_and_halt();
        doReset();
        rom[12'hFFF] = 9'h001;
        startRun();
        repeat (2) step();
        bus.branch_taken  = 1'b1;
        bus.branch_rel    = 1'b0;
        bus.branch_target = 12'hFFF;
        rom[0] = 9'h1FF;
        step();
        bus.branch_taken = 1'b0;
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'hFFF, 9'h001}) begin
            failures++;
            $display("[TB] FAIL wrap_top actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'hFFF, 9'h001});
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'h000, 9'h1FF}) begin
            failures++;
            $display("[TB] FAIL wrap_zero actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h000, 9'h1FF});
        end
        bus.branch_taken  = 1'b1;
        bus.branch_target = 12'h300;
        step();
        bus.branch_taken = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.instr_valid, bus.rom_addr} !== {3'b010, 12'h001}) begin
            failures++;
            $display("[TB] FAIL halt_priority actual=%h required=%h",
                {bus.busy, bus.done, bus.instr_valid, bus.rom_addr}, {3'b010, 12'h001});
        end
    endtask

    task automatic test_midrun_reset();
        fillRom();
        doReset();
        startRun();
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr}
            !== {3'b000, 12'h000, 9'h000, 12'h000}) begin
            failures++;
            $display("[TB] FAIL async_reset actual=%h required=%h",
                {bus.busy, bus.done, bus.instr_valid, bus.instr_pc, bus.instr, bus.rom_addr},
                {3'b000, 12'h000, 9'h000, 12'h000});
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({bus.busy, bus.instr_valid, bus.rom_addr} !== {2'b00, 12'h000}) begin
            failures++;
            $display("[TB] FAIL idle_after_reset actual=%h required=%h",
                {bus.busy, bus.instr_valid, bus.rom_addr}, {2'b00, 12'h000});
        end
        startRun();
        step();
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 12'h000, 9'h000}) begin
            failures++;
            $display("[TB] FAIL restart_pc actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.instr}, {1'b1, 12'h000, 9'h000});
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if ({bus.instr_valid, bus.instr_pc, bus.busy} !== {1'b1, 12'h001, 1'b1}) begin
            failures++;
            $display("[TB] FAIL start_in_run actual=%h required=%h",
                {bus.instr_valid, bus.instr_pc, bus.busy}, {1'b1, 12'h001, 1'b1});
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_rel    = 1'b0;
        bus.branch_target = '0;
        fillRom();
        #1;
        test_reset();
        test_sequential_run();
        test_absolute_branch();
        test_relative_branch();
        test_stall();
        test_wrap_and_halt();
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
